// File: rtl/rca_seq_pkg.sv
// rca_seq_pkg: shared types and constants for the nibble-serial adder sequencer.
//   state_t  : sequencer FSM state encoding
//   SLICE_W  : width of one adder slice (the shared rca4)
//   nslice() : number of slices needed for a given operand width
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: performs a WIDTH-bit add on one external 4-bit ripple-carry
// adder, one nibble per cycle, LSB first. The inter-slice carry is registered
// here, and the sum nibbles are collected into sum_out.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready only in IDLE)
//   a_in, b_in, cin      operands and carry-in, captured on accept
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   sum_out, cout_out    registered sum and carry-out
//   ovf_out              signed overflow; real only when RCA_SEQ_OVF_EN is
//                        defined, otherwise tied to 0
//   add_a, add_b, add_ci drive to the shared rca4 (0 outside BUSY)
//   add_s, add_co        result from the shared rca4
//
// Optional build macro: RCA_SEQ_OVF_EN enables the signed overflow flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; in_ready=1
// BUSY  | one slice per cycle through the adder, idx selects the nibble
// DONE  | result held on outputs until out_ready
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_ci,
  input  logic [3:0]       add_s,
  input  logic             add_co
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state == BUSY) begin
      add_a  = a_reg[SLICE_W*idx +: SLICE_W];
      add_b  = b_reg[SLICE_W*idx +: SLICE_W];
      add_ci = carry_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_out   <= '0;
      cout_out  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_out   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            carry_reg <= cin;
            idx       <= '0;
            sum_out   <= '0;
            cout_out  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
            ovf_out   <= 1'b0;
`endif
            state     <= BUSY;
          end
        end
        BUSY: begin
          sum_out[SLICE_W*idx +: SLICE_W] <= add_s;
          carry_reg <= add_co;
          if (idx == IDX_LAST) begin
            cout_out <= add_co;
`ifdef RCA_SEQ_OVF_EN
            // Same operand signs but a different result sign.
            ovf_out  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (add_s[3] != a_reg[WIDTH-1]);
`endif
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef RCA_SEQ_OVF_EN
  assign ovf_out = 1'b0;
`endif

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb_rca_seq_ctrl: directed-vector bench for rca_seq_ctrl at WIDTH=16 with a
// behavioural rca4 connected to the add_* ports.
module tb_rca_seq_ctrl;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             ovf_out;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_ci;
  logic [3:0]       add_s;
  logic             add_co;

  int n_vec = 0;
  int n_err = 0;

`ifdef RCA_SEQ_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out), .ovf_out(ovf_out),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co)
  );

  // Behavioural rca4
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_ci};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called right after the accept edge. Walks the BUSY cycles, then checks
  // the DONE result. Leaves the block in DONE (out_ready untouched).
  task automatic run_busy(input string tag, input logic [15:0] es, input logic ec,
                          input logic eo, input logic [3:0] eci);
    logic [3:0] ci_seq;
    ci_seq = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ci_seq[k] = add_ci;
      if (k == 0) chk({tag, ".sum_clr"}, 32'(sum_out), 32'h0);
      chk({tag, ".busy_ov"}, 32'(out_valid), 32'h0);
    end
    @(negedge clk);
    chk({tag, ".ovalid"}, 32'(out_valid), 32'h1);
    chk({tag, ".sum"}, 32'(sum_out), 32'(es));
    chk({tag, ".cout"}, 32'(cout_out), 32'(ec));
    chk({tag, ".ovf"}, 32'(ovf_out), 32'(eo & OVF_ON));
    chk({tag, ".ci_seq"}, 32'(ci_seq), 32'(eci));
  endtask

  task automatic accept(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c);
    @(negedge clk);
    chk({tag, ".iready"}, 32'(in_ready), 32'h1);
    a_in = a; b_in = b; cin = c; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic release_done();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] es, input logic ec,
                       input logic eo, input logic [3:0] eci);
    accept(tag, a, b, c);
    run_busy(tag, es, ec, eo, eci);
    release_done();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.iready", 32'(in_ready), 32'h1);
    chk("rst.ovalid", 32'(out_valid), 32'h0);
    chk("rst.sum", 32'(sum_out), 32'h0);
    chk("rst.cout", 32'(cout_out), 32'h0);
    chk("rst.ovf", 32'(ovf_out), 32'h0);
    chk("rst.add", 32'({add_a, add_b, add_ci}), 32'h0);

    // ci sequence packed with slice 0 in bit 0
    do_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000);
    do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110);
    do_op("t3", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111);
    do_op("t4", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0100);

    // Backpressure: DONE held while a new request waits
    accept("bp", 16'h1111, 16'h2222, 1'b0);
    run_busy("bp", 16'h3333, 1'b0, 1'b0, 4'b0000);
    a_in = 16'h5555; b_in = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp.hold_sum", 32'(sum_out), 32'h3333);
      chk("bp.hold_irdy", 32'(in_ready), 32'h0);
      chk("bp.hold_ov", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp.idle_irdy", 32'(in_ready), 32'h1);
    chk("bp.idle_sum", 32'(sum_out), 32'h3333);
    @(posedge clk);
    #1 in_valid = 1'b0;
    run_busy("bp2", 16'h6666, 1'b0, 1'b0, 4'b0000);
    release_done();

    // Reset while BUSY at idx=2
    accept("rb", 16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rb.iready", 32'(in_ready), 32'h1);
    chk("rb.ovalid", 32'(out_valid), 32'h0);
    chk("rb.sum", 32'(sum_out), 32'h0);
    chk("rb.cout", 32'(cout_out), 32'h0);
    chk("rb.add", 32'({add_a, add_b, add_ci}), 32'h0);
    do_op("rb2", 16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0, 1'b0, 4'b0000);

    // Signed overflow cases
    do_op("ov1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110);
    do_op("ov2", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
